// File: rtl/cdrtrig_pkg.sv
// Shared types and constants for the CDR trigger path: trigger modes,
// lane/pattern geometry and the decoded 8B/10B symbol record.
package cdrtrig_pkg;

    localparam int NUM_LANES   = 4;
    localparam int PATTERN_LEN = 10;

    typedef enum logic [7:0] {
        MODE_8B10B_PATTERN  = 8'h00,
        MODE_8B10B_DISP     = 8'h01,
        MODE_64B66B_PATTERN = 8'h80,
        MODE_64B66B_INVALID = 8'h81
    } trig_mode_e;

    typedef struct packed {
        logic [7:0] data_byte;
        logic       is_ctl;
        logic       err;
    } sym_t;

    // Lane 3 is earliest in time, so the highest set lane is the earliest hit.
    function automatic logic [1:0] highest_lane(input logic [3:0] lanes);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/cdrtrig_window_compare.sv
// Combinational compare of one 10-symbol window against the configured
// pattern bytes, control/data types and don't-care mask.
module cdrtrig_window_compare #(
    parameter int PATTERN_LEN = cdrtrig_pkg::PATTERN_LEN
) (
    input  cdrtrig_pkg::sym_t [PATTERN_LEN-1:0] win,
    input  logic [8*PATTERN_LEN-1:0]            cfg_data,
    input  logic [PATTERN_LEN-1:0]              cfg_type,
    input  logic [PATTERN_LEN-1:0]              cfg_mask,
    output logic                                match
);
    import cdrtrig_pkg::*;

    logic [PATTERN_LEN-1:0] sym_ok;

    for (genvar gi = 0; gi < PATTERN_LEN; gi++) begin : g_sym
        // A flagged invalid codeword never satisfies a checked position.
        assign sym_ok[gi] = ~cfg_mask[gi]
                          | (~win[gi].err
                             & (win[gi].data_byte == cfg_data[8*gi +: 8])
                             & (win[gi].is_ctl == cfg_type[gi]));
    end

    assign match = &sym_ok;

endmodule

// File: rtl/cdrtrig_8b10b_pattern_match.sv
// Four-lane 8B/10B pattern / disparity-error trigger with a two-stage pipeline.
// Define CDRTRIG_8B10B_HOLDOFF_EN to add a post-trigger holdoff down-counter.
module cdrtrig_8b10b_pattern_match #(
    parameter int NUM_LANES     = cdrtrig_pkg::NUM_LANES,
    parameter int PATTERN_LEN   = cdrtrig_pkg::PATTERN_LEN,
    parameter int HOLDOFF_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     locked,
    input  logic                     sym_valid,
    input  logic [8*NUM_LANES-1:0]   sym_data,
    input  logic [NUM_LANES-1:0]     sym_is_ctl,
    input  logic [NUM_LANES-1:0]     sym_disp_err,
    input  logic [NUM_LANES-1:0]     sym_err,
    input  logic [7:0]               cfg_mode,
    input  logic [8*PATTERN_LEN-1:0] cfg_data,
    input  logic [PATTERN_LEN-1:0]   cfg_type,
    input  logic [PATTERN_LEN-1:0]   cfg_mask,
    input  logic                     cfg_flush,
    input  logic [HOLDOFF_WIDTH-1:0] cfg_holdoff,
    output logic                     trig_out,
    output logic [1:0]               trig_pos
);
    import cdrtrig_pkg::*;

    localparam int HIST_LEN = PATTERN_LEN - 1;
    localparam int WIN_LEN  = PATTERN_LEN + NUM_LANES - 1;

    // Window index 0 is the earliest symbol; the current word occupies the top.
    sym_t [HIST_LEN-1:0]  hist_reg;
    sym_t [NUM_LANES-1:0] cur_syms;
    sym_t [WIN_LEN-1:0]   win;

    logic [1:0]           fill_reg;
    logic [NUM_LANES-1:0] align_match;
    logic [NUM_LANES-1:0] align_elig;
    logic [NUM_LANES-1:0] pat_lane_hit;
    logic [NUM_LANES-1:0] lane_hit_next;
    logic [NUM_LANES-1:0] lane_hit_reg;
    logic                 trig_out_reg;
    logic [1:0]           trig_pos_reg;

    logic history_inval;
    logic word_ok;
    logic mode_pattern;
    logic mode_disp;
    logic holdoff_clear;
    logic fire;

    assign history_inval = cfg_flush | ~locked;
    assign word_ok       = sym_valid & ~history_inval;
    assign mode_pattern  = (cfg_mode == MODE_8B10B_PATTERN);
    assign mode_disp     = (cfg_mode == MODE_8B10B_DISP);

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_cur
        assign cur_syms[gi] = {sym_data[8*(NUM_LANES-1-gi) +: 8],
                               sym_is_ctl[NUM_LANES-1-gi],
                               sym_err[NUM_LANES-1-gi]};
    end

    assign win = {cur_syms, hist_reg};

    // Alignment gi ends on current lane NUM_LANES-1-gi; its lane hit is stored by lane.
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_align
        cdrtrig_window_compare #(
            .PATTERN_LEN (PATTERN_LEN)
        ) u_cmp (
            .win      (win[gi +: PATTERN_LEN]),
            .cfg_data (cfg_data),
            .cfg_type (cfg_type),
            .cfg_mask (cfg_mask),
            .match    (align_match[gi])
        );

        assign align_elig[gi] = (NUM_LANES * int'(fill_reg) + gi + 1) >= PATTERN_LEN;
        assign pat_lane_hit[NUM_LANES-1-gi] = align_match[gi] & align_elig[gi];
    end

    always_comb begin
        lane_hit_next = '0;
        if (word_ok) begin
            if (mode_pattern && (|cfg_mask)) begin
                lane_hit_next = pat_lane_hit;
            end else if (mode_disp) begin
                lane_hit_next = sym_disp_err | sym_err;
            end
        end
    end

    // Stage-1 hits are dropped if lock or configuration changes underneath them.
    assign fire = (|lane_hit_reg) & ~history_inval & holdoff_clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_reg     <= '0;
            fill_reg     <= 2'd0;
            lane_hit_reg <= '0;
            trig_out_reg <= 1'b0;
            trig_pos_reg <= 2'd0;
        end else begin
            if (history_inval) begin
                fill_reg <= 2'd0;
            end else if (sym_valid && (fill_reg != 2'd3)) begin
                fill_reg <= fill_reg + 2'd1;
            end

            if (word_ok) begin
                hist_reg <= win[WIN_LEN-1:NUM_LANES];
            end

            lane_hit_reg <= lane_hit_next;
            trig_out_reg <= fire;
            if (fire) begin
                trig_pos_reg <= highest_lane(lane_hit_reg);
            end
        end
    end

`ifdef CDRTRIG_8B10B_HOLDOFF_EN
    logic [HOLDOFF_WIDTH-1:0] holdoff_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            holdoff_cnt_reg <= '0;
        end else if (cfg_flush) begin
            holdoff_cnt_reg <= '0;
        end else if (fire) begin
            holdoff_cnt_reg <= cfg_holdoff;
        end else if (holdoff_cnt_reg != '0) begin
            holdoff_cnt_reg <= holdoff_cnt_reg - HOLDOFF_WIDTH'(1);
        end
    end

    assign holdoff_clear = (holdoff_cnt_reg == '0);
`else
    logic unused_cfg_holdoff;
    assign unused_cfg_holdoff = ^cfg_holdoff;
    assign holdoff_clear      = 1'b1;
`endif

    assign trig_out = trig_out_reg;
    assign trig_pos = trig_pos_reg;

endmodule

// File: tb/tb_cdrtrig_8b10b_pattern_match.sv
// Directed bench for cdrtrig_8b10b_pattern_match: pattern alignments, fill
// eligibility, type/error/mask handling, disparity mode and optional holdoff.
module tb_cdrtrig_8b10b_pattern_match;

    logic        clk = 1'b0;
    logic        rst;
    logic        locked;
    logic        sym_valid;
    logic [31:0] sym_data;
    logic [3:0]  sym_is_ctl;
    logic [3:0]  sym_disp_err;
    logic [3:0]  sym_err;
    logic [7:0]  cfg_mode;
    logic [79:0] cfg_data;
    logic [9:0]  cfg_type;
    logic [9:0]  cfg_mask;
    logic        cfg_flush;
    logic [15:0] cfg_holdoff;
    logic        trig_out;
    logic [1:0]  trig_pos;

    int    checks = 0;
    int    errors = 0;
    string tag;

    // K28.5 (0xBC, control) at even positions, D21.5 (0xB5, data) at odd.
    localparam logic [79:0] PAT_DATA = {5{8'hB5, 8'hBC}};
    localparam logic [9:0]  PAT_TYPE = 10'h155;

    always #5 clk = ~clk;

    cdrtrig_8b10b_pattern_match dut (
        .clk          (clk),
        .rst          (rst),
        .locked       (locked),
        .sym_valid    (sym_valid),
        .sym_data     (sym_data),
        .sym_is_ctl   (sym_is_ctl),
        .sym_disp_err (sym_disp_err),
        .sym_err      (sym_err),
        .cfg_mode     (cfg_mode),
        .cfg_data     (cfg_data),
        .cfg_type     (cfg_type),
        .cfg_mask     (cfg_mask),
        .cfg_flush    (cfg_flush),
        .cfg_holdoff  (cfg_holdoff),
        .trig_out     (trig_out),
        .trig_pos     (trig_pos)
    );

    // Checks the result for the word driven two steps earlier, then drives a new slot.
    task automatic step(input logic v, input logic [31:0] d, input logic [3:0] c,
                        input logic [3:0] e, input logic [3:0] de,
                        input logic et, input logic [1:0] ep);
        @(negedge clk);
        checks++;
        assert (trig_out === et) else begin
            errors++;
            $error("FAIL %s trig_out got %b expected %b", tag, trig_out, et);
        end
        if (et) begin
            checks++;
            assert (trig_pos === ep) else begin
                errors++;
                $error("FAIL %s trig_pos got %0d expected %0d", tag, trig_pos, ep);
            end
        end
        $display("step %s v=%b data=%h ctl=%b err=%b disp=%b trig=%b pos=%0d",
                 tag, v, d, c, e, de, trig_out, trig_pos);
        sym_valid    = v;
        sym_data     = d;
        sym_is_ctl   = c;
        sym_err      = e;
        sym_disp_err = de;
    endtask

    task automatic w(input logic [31:0] d, input logic [3:0] c,
                     input logic et, input logic [1:0] ep);
        step(1'b1, d, c, 4'b0, 4'b0, et, ep);
    endtask

    task automatic idle(input logic et, input logic [1:0] ep);
        step(1'b0, 32'h0, 4'b0, 4'b0, 4'b0, et, ep);
    endtask

    task automatic do_flush();
        @(negedge clk);
        cfg_flush = 1'b1;
        sym_valid = 1'b0;
        @(negedge clk);
        cfg_flush = 1'b0;
    endtask

    // Flush, then four words; only the last one may complete a match.
    task automatic run4(input logic [31:0] d0, input logic [3:0] c0,
                        input logic [31:0] d1, input logic [3:0] c1,
                        input logic [31:0] d2, input logic [3:0] c2,
                        input logic [31:0] d3, input logic [3:0] c3,
                        input logic [3:0] e3, input logic exp, input logic [1:0] pos);
        do_flush();
        w(d0, c0, 1'b0, 2'd0);
        w(d1, c1, 1'b0, 2'd0);
        w(d2, c2, 1'b0, 2'd0);
        step(1'b1, d3, c3, e3, 4'b0, 1'b0, 2'd0);
        idle(1'b0, 2'd0);
        idle(exp, pos);
        idle(1'b0, 2'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        locked       = 1'b1;
        sym_valid    = 1'b0;
        sym_data     = '0;
        sym_is_ctl   = '0;
        sym_disp_err = '0;
        sym_err      = '0;
        cfg_mode     = 8'h00;
        cfg_data     = PAT_DATA;
        cfg_type     = PAT_TYPE;
        cfg_mask     = 10'h3FF;
        cfg_flush    = 1'b0;
        cfg_holdoff  = 16'd20;

        tag = "reset";
        repeat (3) @(negedge clk);
        checks += 2;
        assert (trig_out === 1'b0) else begin
            errors++;
            $error("FAIL reset trig_out got %b expected 0", trig_out);
        end
        assert (trig_pos === 2'd0) else begin
            errors++;
            $error("FAIL reset trig_pos got %0d expected 0", trig_pos);
        end
        rst = 1'b0;
        idle(1'b0, 2'd0);

        tag = "lane0";
        run4(32'h00000000, 4'b0000, 32'h0000BCB5, 4'b0010,
             32'hBCB5BCB5, 4'b1010, 32'hBCB5BCB5, 4'b1010, 4'b0000, 1'b1, 2'd0);

        tag = "lane2";
        run4(32'h00000000, 4'b0000, 32'hBCB5BCB5, 4'b1010,
             32'hBCB5BCB5, 4'b1010, 32'hBCB50000, 4'b1000, 4'b0000, 1'b1, 2'd2);

        // Stale history would complete a k=0 match, but fill is only 2.
        tag = "fill2_k0";
        w(32'h000000BC, 4'b0001, 1'b0, 2'd0);
        idle(1'b0, 2'd0);
        idle(1'b0, 2'd0);
        do_flush();
        w(32'hB5BCB5BC, 4'b0101, 1'b0, 2'd0);
        w(32'hB5BCB5BC, 4'b0101, 1'b0, 2'd0);
        w(32'hB5000000, 4'b0000, 1'b0, 2'd0);
        idle(1'b0, 2'd0);
        idle(1'b0, 2'd0);
        idle(1'b0, 2'd0);

        tag = "fill2_k1";
        do_flush();
        w(32'hBCB5BCB5, 4'b1010, 1'b0, 2'd0);
        w(32'hBCB5BCB5, 4'b1010, 1'b0, 2'd0);
        w(32'hBCB50000, 4'b1000, 1'b0, 2'd0);
        idle(1'b0, 2'd0);
        idle(1'b1, 2'd2);
        idle(1'b0, 2'd0);

        tag = "ctl_inverted";
        run4(32'h00000000, 4'b0000, 32'h0000BCB5, 4'b0010,
             32'hBCB5BCB5, 4'b1010, 32'hBCB5BCB5, 4'b1000, 4'b0000, 1'b0, 2'd0);

        tag = "ctl_masked";
        cfg_mask = 10'h2FF;
        run4(32'h00000000, 4'b0000, 32'h0000BCB5, 4'b0010,
             32'hBCB5BCB5, 4'b1010, 32'hBCB5BCB5, 4'b1000, 4'b0000, 1'b1, 2'd0);

        tag = "sym_err";
        cfg_mask = 10'h3FF;
        run4(32'h00000000, 4'b0000, 32'h0000BCB5, 4'b0010,
             32'hBCB5BCB5, 4'b1010, 32'hBCB5BCB5, 4'b1010, 4'b0001, 1'b0, 2'd0);

        tag = "err_masked";
        cfg_mask = 10'h1FF;
        run4(32'h00000000, 4'b0000, 32'h0000BCB5, 4'b0010,
             32'hBCB5BCB5, 4'b1010, 32'hBCB5BCB5, 4'b1010, 4'b0001, 1'b1, 2'd0);

        // Repeating stream: alignments k=1 and k=3 both hit, earliest is lane 2.
        tag = "overlap";
        cfg_mask = 10'h3FF;
        do_flush();
        w(32'hBCB5BCB5, 4'b1010, 1'b0, 2'd0);
        w(32'hBCB5BCB5, 4'b1010, 1'b0, 2'd0);
        w(32'hBCB5BCB5, 4'b1010, 1'b0, 2'd0);
        w(32'hBCB5BCB5, 4'b1010, 1'b0, 2'd0);
        w(32'hBCB5BCB5, 4'b1010, 1'b1, 2'd2);
        idle(1'b1, 2'd2);
        idle(1'b1, 2'd2);
        idle(1'b0, 2'd0);
        idle(1'b0, 2'd0);

        tag = "mask_zero";
        cfg_mask = 10'h000;
        do_flush();
        for (int i = 0; i < 1000; i++) begin
            w($urandom, 4'($urandom), 1'b0, 2'd0);
        end
        idle(1'b0, 2'd0);
        idle(1'b0, 2'd0);
        idle(1'b0, 2'd0);

        tag = "disp";
        cfg_mode = 8'h01;
        cfg_mask = 10'h3FF;
        do_flush();
        step(1'b1, 32'h12345678, 4'b0000, 4'b0000, 4'b0100, 1'b0, 2'd0);
        idle(1'b0, 2'd0);
        idle(1'b1, 2'd2);
        idle(1'b0, 2'd0);
        step(1'b1, 32'h12345678, 4'b0000, 4'b0010, 4'b0000, 1'b0, 2'd0);
        idle(1'b0, 2'd0);
        idle(1'b1, 2'd1);
        step(1'b1, 32'h12345678, 4'b0000, 4'b0010, 4'b1000, 1'b0, 2'd0);
        idle(1'b0, 2'd0);
        idle(1'b1, 2'd3);
        idle(1'b0, 2'd0);

        tag = "disp_unlocked";
        locked = 1'b0;
        step(1'b1, 32'h12345678, 4'b0000, 4'b0000, 4'b0100, 1'b0, 2'd0);
        idle(1'b0, 2'd0);
        idle(1'b0, 2'd0);
        idle(1'b0, 2'd0);
        locked = 1'b1;

        tag = "bad_mode";
        cfg_mode = 8'h80;
        do_flush();
        step(1'b1, 32'h12345678, 4'b0000, 4'b1111, 4'b1111, 1'b0, 2'd0);
        idle(1'b0, 2'd0);
        idle(1'b0, 2'd0);
        idle(1'b0, 2'd0);

`ifdef CDRTRIG_8B10B_HOLDOFF_EN
        // Matches every word from the third onward; holdoff of 20 spaces pulses by 21.
        tag = "holdoff";
        cfg_mode    = 8'h00;
        cfg_holdoff = 16'd20;
        do_flush();
        for (int s = 0; s < 50; s++) begin
            int n;
            n = s - 2;
            w(32'hBCB5BCB5, 4'b1010, (n >= 2) && (((n - 2) % 21) == 0), 2'd2);
        end
        @(negedge clk);
        rst       = 1'b1;
        sym_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tag = "holdoff_rst";
        w(32'hBCB5BCB5, 4'b1010, 1'b0, 2'd0);
        w(32'hBCB5BCB5, 4'b1010, 1'b0, 2'd0);
        w(32'hBCB5BCB5, 4'b1010, 1'b0, 2'd0);
        w(32'hBCB5BCB5, 4'b1010, 1'b0, 2'd0);
        w(32'hBCB5BCB5, 4'b1010, 1'b1, 2'd2);
        idle(1'b0, 2'd0);
        idle(1'b0, 2'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdrtrig_8b10b_pattern_match.md
Name: cdrtrig_8b10b_pattern_match

Overview:
Consumes the four-lane decoded 8B/10B symbol stream, after the decoders, and raises a trigger when a configurable 10-symbol pattern appears at any lane alignment.
Also supports a disparity/symbol-error trigger mode.
Sits between the 8B/10B decode/align stage and the trigger output mux in the CDR trigger path.
Configuration arrives already synchronized into clk as quasi-static vectors from the register block.

Parameters:
NUM_LANES, 4, symbols per input word (fixed by gearbox; other values unsupported)
PATTERN_LEN, 10, symbols in match pattern
HOLDOFF_WIDTH, 16, width of holdoff counter/config

Ports:
clk  in  1  rx symbol clock; all logic in this domain
rst  in  1  asynchronous, active-high reset
locked  in  1  8B/10B symbol lock (all lanes locked or comma-free)
sym_valid  in  1  decoded word valid (all 4 lanes together)
sym_data  in  32  lane g byte at [8g+:8]; lane 3 earliest in time, lane 0 latest
sym_is_ctl  in  4  per-lane K-symbol flag
sym_disp_err  in  4  per-lane disparity error
sym_err  in  4  per-lane invalid-codeword flag
cfg_mode  in  8  0x00 pattern match, 0x01 disparity/symbol error; other values never trigger
cfg_data  in  80  pattern byte i at [8i+:8], i=0 earliest
cfg_type  in  10  bit i: 1=control expected, 0=data
cfg_mask  in  10  bit i: 1=checked, 0=don't care
cfg_flush  in  1  single-cycle pulse on any config write; clears history
cfg_holdoff  in  16  holdoff length in clk cycles (used only with feature)
trig_out  out  1  single-cycle trigger pulse
trig_pos  out  2  lane index of the symbol completing the match (earliest completing alignment wins)

Behaviour:
- Reset: trig_out=0, trig_pos=0, history cleared, fill count=0.
- History: on sym_valid, shift in the 4 current symbols. Each symbol carries {byte, is_ctl, err}. Keep the last 9 symbols plus the current 4 (13-symbol window).
- Fill counter: counts valid words, saturating at 3. Cleared by rst, cfg_flush, or locked=0.
- Alignment k (k=0..3) ends on current-word lane 3-k. Window = the 10 symbols ending there.
- Alignment k is eligible only if 4*fill + (k+1) >= 10, i.e. fill=2 with k>=1, or fill=3.
- Symbol i matches when mask[i]=0, or when all of the following hold: err=0, byte==cfg_data[i], and is_ctl==cfg_type[i].
- Alignment hits when eligible, locked=1, cfg_mode=0x00, and all 10 symbols match.
- cfg_mask==0 never triggers.
- Disparity mode (0x01): hit when sym_valid, locked=1, and |(sym_disp_err|sym_err) is set. trig_pos = highest-index (earliest) lane with an error.
- Pipeline: stage 1 registers per-alignment compare results; stage 2 ORs them, priority-encodes, and registers trig_out/trig_pos.
  - Latency: trig_out rises exactly 2 clk after the sym_valid word that completes the match.
- Multiple alignments hit in one word: one pulse; trig_pos = lane of the earliest-completing alignment.
- Patterns overlapping across consecutive words trigger on every completing word. No internal suppression without the feature.
- sym_valid=0: no shift, no compare, pipeline emits no trigger for that slot.
- locked deassert or cfg_flush: history invalidated the same cycle. Hits already in stage 1 are discarded.
- cfg_mode change without flush is undefined; the register block always pulses cfg_flush.

Optional Feature:
CDRTRIG_8B10B_HOLDOFF_EN
- Defined: after a trig_out pulse, a down-counter loads cfg_holdoff. Hits are suppressed while the counter is nonzero.
  - cfg_holdoff=0 means no holdoff.
  - rst and cfg_flush clear the counter.
- Undefined: cfg_holdoff is ignored and no counter is synthesized. Every hit pulses trig_out.

Decomposition:
- Package cdrtrig_pkg holds:
  - trig mode enum (MODE_8B10B_PATTERN=0x00, MODE_8B10B_DISP=0x01, MODE_64B66B_PATTERN=0x80, MODE_64B66B_INVALID=0x81)
  - NUM_LANES and PATTERN_LEN constants
  - packed symbol struct {byte, is_ctl, err}
- One sub-module, cdrtrig_window_compare, instantiated 4x: combinational 10-symbol window vs pattern/type/mask, outputs a match bit.

Test Plan:
- Pattern K28.5,D21.5 repeated, mask=0x3FF, fill saturated, pattern ending on lane 0 → trig_out pulse 2 cycles after the word, trig_pos=0.
- Same pattern shifted so it ends on lane 2 → trig_pos=2. Also check fill=2 with a pattern ending on lane 3 (k=0) → no trigger; ending on lane 2 → trigger.
- Matching bytes but one symbol has is_ctl inverted, or sym_err=1 at a checked position → no trigger; clear that mask bit → trigger.
- cfg_mask=0x000 with arbitrary data → trig_out never asserts over 1000 words.
- cfg_mode=0x01, inject sym_disp_err=4'b0100 → single pulse, trig_pos=2. Same injection with locked=0 → no pulse.
- With CDRTRIG_8B10B_HOLDOFF_EN and cfg_holdoff=20: matches every word → pulses spaced 21 cycles apart. Assert rst mid-holdoff → next match triggers immediately.
